// File: rtl/spi_tx_packet_fifo.sv
// Packet-mode byte FIFO feeding an SPI master.
// A whole AXI-Stream packet (delimited by tlast) is buffered and its length
// counted. Once committed, the packet is launched with a one-cycle trigger
// carrying num_bytes, and its bytes are streamed to the master. The next
// packet is not launched until the master reports idle again.
// LEN_DEPTH_G must be a power of two >= 2; DEPTH_G a power of two >= 4.
module spi_tx_packet_fifo #(
  parameter int DEPTH_G     = 16,
  parameter int LEN_DEPTH_G = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  // upstream byte stream
  input  logic [7:0]                     s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  // downstream byte stream to the SPI master
  output logic [7:0]                     m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  // SPI master control
  output logic                           trigger,
  output logic [31:0]                    num_bytes,
  input  logic                           spi_busy,
  // status
  output logic [$clog2(LEN_DEPTH_G):0]   pkt_count,
  output logic                           oversize_err,
  input  logic                           err_clr
);

  localparam int AW  = $clog2(DEPTH_G);      // byte RAM address width
  localparam int LW  = AW + 1;               // packet length width (1..DEPTH_G)
  localparam int LAW = $clog2(LEN_DEPTH_G);  // length FIFO address width

  localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH_G - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // storage (data only, never reset)
  logic [8:0]    mem_q     [DEPTH_G];
  logic [LW-1:0] len_mem_q [LEN_DEPTH_G];

  // byte FIFO pointers, one bit wider than the address
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  // length FIFO pointers
  logic [LAW:0]  lwr_ptr_q, lwr_ptr_d;
  logic [LAW:0]  lrd_ptr_q, lrd_ptr_d;

  // write-side control
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          discard_q, discard_d;
  logic          err_q, err_d;
  logic          rdy_en_q;

  // read-side control
  state_t        state_q, state_d;
  logic          trig_q, trig_d;
  logic [LW-1:0] nb_q, nb_d;

  // status decodes
  logic          byte_empty, byte_full;
  logic          len_empty, len_full;
  logic          cnt_at_max;
  logic          wr_fire, store, commit, overflow;
  logic          rd_fire;
  logic [8:0]    head;

  assign byte_empty = (wr_ptr_q == rd_ptr_q);
  assign byte_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign len_empty  = (lwr_ptr_q == lrd_ptr_q);
  assign len_full   = (lwr_ptr_q[LAW] != lrd_ptr_q[LAW]) &&
                      (lwr_ptr_q[LAW-1:0] == lrd_ptr_q[LAW-1:0]);
  assign cnt_at_max = (wr_cnt_q == CNT_MAX);

  // Ready never looks at tvalid. A byte that would commit a length is held
  // off while the length FIFO is full; discarding swallows everything.
  // rdy_en_q keeps ready low throughout reset and until the first edge after.
  assign s_axis_tready = rdy_en_q &&
                         ((!byte_full && !(len_full && (s_axis_tlast || cnt_at_max))) ||
                          discard_q);

  assign wr_fire  = s_axis_tvalid && s_axis_tready;
  assign store    = wr_fire && !discard_q;
  assign commit   = store && (s_axis_tlast || cnt_at_max);
  assign overflow = store && !s_axis_tlast && cnt_at_max;

  // First-word fall-through head; outputs are forced to zero when not valid
  // so the stream reads all-zero out of reset.
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tvalid = (state_q == ST_STREAM) && !byte_empty;
  assign m_axis_tdata  = m_axis_tvalid ? head[7:0] : 8'h00;
  assign m_axis_tlast  = m_axis_tvalid && head[8];
  assign rd_fire       = m_axis_tvalid && m_axis_tready;

  assign trigger      = trig_q;
  assign num_bytes    = 32'(nb_q);
  assign pkt_count    = lwr_ptr_q - lrd_ptr_q;
  assign oversize_err = err_q;

  // Write side: byte pointer, per-packet count, length commit, oversize handling
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_cnt_d  = wr_cnt_q;
    lwr_ptr_d = lwr_ptr_q;
    discard_d = discard_q;
    err_d     = err_q;

    // the dropped tail of an oversize packet ends with its own tlast byte
    if (wr_fire && discard_q && s_axis_tlast) begin
      discard_d = 1'b0;
    end

    if (store) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end

    if (commit) begin
      lwr_ptr_d = lwr_ptr_q + (LAW+1)'(1);
      wr_cnt_d  = '0;
    end else if (store) begin
      wr_cnt_d  = wr_cnt_q + AW'(1);
    end

    if (overflow) begin
      discard_d = 1'b1;
    end

    // a same-cycle set beats the clear
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (overflow) begin
      err_d = 1'b1;
    end
  end

  // Storage writes; the last flag is forced on when a packet is truncated
  always_ff @(posedge clk_in) begin
    if (store) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {commit, s_axis_tdata};
    end
    if (commit) begin
      len_mem_q[lwr_ptr_q[LAW-1:0]] <= {1'b0, wr_cnt_q} + LW'(1);
    end
  end

  // Read side FSM: launch when a packet is queued and the master is idle,
  // stream its bytes, then wait for the master to finish shifting
  always_comb begin
    state_d   = state_q;
    trig_d    = 1'b0;
    nb_d      = nb_q;
    rd_ptr_d  = rd_ptr_q;
    lrd_ptr_d = lrd_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (!len_empty && !spi_busy) begin
          trig_d    = 1'b1;
          nb_d      = len_mem_q[lrd_ptr_q[LAW-1:0]];
          lrd_ptr_d = lrd_ptr_q + (LAW+1)'(1);
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rd_fire) begin
          rd_ptr_d = rd_ptr_q + (AW+1)'(1);
          if (head[8]) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!spi_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset drops every buffered byte and queued length
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lwr_ptr_q <= '0;
      lrd_ptr_q <= '0;
      wr_cnt_q  <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      nb_q      <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lwr_ptr_q <= lwr_ptr_d;
      lrd_ptr_q <= lrd_ptr_d;
      wr_cnt_q  <= wr_cnt_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      rdy_en_q  <= 1'b1;
      state_q   <= state_d;
      trig_q    <= trig_d;
      nb_q      <= nb_d;
    end
  end

endmodule

// File: doc/spi_tx_packet_fifo.md
# spi_tx_packet_fifo

- Packet-mode byte FIFO that sits directly upstream of `spi_master_wrapper`.
- Buffers an AXI-Stream byte packet (delimited by `tlast`) and counts its length.
- Once the whole packet is stored, it pulses `trigger` with `num_bytes` and streams the bytes into the SPI master's `s_axis` port.
- It waits for the master to go idle before launching the next packet, so software-side producers need never know the transaction length in advance.

## Interface

**Parameters**
- `DEPTH_G`, 16: byte storage depth; power of two, ≥4.
- `LEN_DEPTH_G`, 4: number of committed packets that can be queued; power of two.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_in` in 1: clock.
  - `rst_in` in 1: asynchronous active-low reset.
- Upstream stream:
  - `s_axis_tdata` in 8: upstream byte.
  - `s_axis_tvalid` in 1: upstream valid.
  - `s_axis_tready` out 1: ready to accept a byte.
  - `s_axis_tlast` in 1: last byte of packet.
- Downstream stream (to the SPI master `s_axis`):
  - `m_axis_tdata` out 8: byte to the SPI master.
  - `m_axis_tvalid` out 1: valid to the SPI master.
  - `m_axis_tready` in 1: SPI master ready.
  - `m_axis_tlast` out 1: last byte of the packet.
- SPI master control:
  - `trigger` out 1: one-cycle start pulse to the SPI master.
  - `num_bytes` out 32: length of the launched packet, zero-extended.
  - `spi_busy` in 1: SPI master busy. It is high from the cycle after `trigger` until the last bit has shifted.
- Status:
  - `pkt_count` out $clog2(LEN_DEPTH_G)+1: committed packets not yet launched.
  - `oversize_err` out 1: sticky; a packet exceeded `DEPTH_G` bytes.
  - `err_clr` in 1: clears `oversize_err`.

## Operation

**Storage**
- Byte RAM of `DEPTH_G` × 9 bits (data plus last flag), with read/write pointers one bit wider than the address.
- Length FIFO of `LEN_DEPTH_G` × `$clog2(DEPTH_G)+1` bits.

**Write side**
- `s_axis_tready` = !byte_full && !(len_full && (s_axis_tlast || wr_cnt==DEPTH_G-1)) || discarding.
- `wr_cnt` counts bytes of the current packet.
- On a handshake with `tlast`:
  - store last flag = 1;
  - push `wr_cnt+1` into the length FIFO;
  - clear `wr_cnt`.
- Oversize:
  - When byte number `DEPTH_G` of a packet is accepted without `tlast`, it is stored with last flag forced to 1 and length `DEPTH_G` is committed.
  - `oversize_err` is set and the block enters discarding.
  - While discarding, `tready` = 1 and bytes are dropped through the byte carrying `tlast`, inclusive.
- Empty packets cannot occur; the minimum length is 1.

**Read side FSM**
- **IDLE**: when len FIFO is non-empty and `spi_busy`=0:
  - register `trigger`=1 for one cycle;
  - load `num_bytes` from the len FIFO head and pop it;
  - go to STREAM.
- **STREAM**:
  - `m_axis_tvalid` = byte FIFO non-empty.
  - `m_axis_tdata`/`m_axis_tlast` come from the head entry (first-word fall-through).
  - On a handshake with last=1, go to DRAIN.
- **DRAIN**: go to IDLE on the first cycle `spi_busy`=0 is sampled.

**Status and held values**
- `num_bytes` holds its value until the next `trigger`.
- `pkt_count` = len FIFO occupancy.
- `err_clr` has priority below a same-cycle set; the set wins.

## Timing

**Reset values**
- `s_axis_tready`=0 while `rst_in`=0, then 1 from the first cycle after release.
- `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
- `trigger`=0, `num_bytes`=0, `pkt_count`=0, `oversize_err`=0.
- FSM=IDLE, all pointers 0.

**Latency**
- `tlast` accepted at edge N → `pkt_count` increments after N.
- `trigger` is high during cycle N+2 if `spi_busy`=0.
- `m_axis_tvalid` rises in that same cycle.

**Handshake rules**
- `m_axis_tvalid`/`tdata` stay stable until `tready`.
- `s_axis_tready` never depends on `s_axis_tvalid`.

**Boundary conditions**
- No write pass-through: a full FIFO accepts a write only in a cycle after a read has freed space.
- A simultaneous read and write of a non-full, non-empty FIFO keeps occupancy constant.
- Pointer wrap at `DEPTH_G` is natural binary.
- Full = MSBs differ and low bits equal; empty = pointers equal.
- A bare `trigger` is never issued without ≥1 stored byte.
- Reset mid-operation discards all buffered bytes and queued lengths and returns the FSM to IDLE.

## Test plan

1. **Single packet.** Send 0x37, 0x48, 0x59 (tlast on 0x59), with `spi_busy`=0 and `m_axis_tready`=1.
   - One `trigger` pulse, `num_bytes`=3.
   - `m_axis` emits 37, 48, 59 with `tlast` only on 59.
2. **Back-to-back packets.** Send packets {C8, B7} and {A6}; hold `spi_busy`=1 for 20 cycles after the first `trigger`.
   - Second `trigger` occurs ≥1 cycle after `spi_busy` falls, with `num_bytes`=1.
   - `pkt_count` goes 2→1→0.
3. **Byte-full.** With `DEPTH_G`=16 and `spi_busy`=1, send a 16-byte packet 0x00..0x0F.
   - All 16 bytes are accepted.
   - `s_axis_tready`=0 after the 16th byte.
   - When busy is released, `num_bytes`=16 and the stream is 00..0F.
4. **Oversize.** Send a 20-byte packet.
   - 16 bytes are streamed with `tlast` on byte 16, `num_bytes`=16.
   - Bytes 17–20 are accepted and dropped.
   - `oversize_err`=1; it clears on `err_clr`.
5. **Length-full.** With `LEN_DEPTH_G`=4 and `spi_busy`=1, send 5 one-byte packets.
   - `tready`=0 on the 5th byte until one packet launches.
6. **Reset mid-stream.** Assert `rst_in`=0 in STREAM after 1 of 3 bytes.
   - All outputs return to reset values immediately.
   - `pkt_count`=0 and no further `trigger` occurs.
